// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch stage and the core.
//   DEFAULT_INSTR_WIDTH : instruction word width (must match simple_cpu)
//   DEFAULT_PC_BITS     : program counter width (memory holds 2^PC_BITS words)
//   HALT_INSTR          : all-ones sentinel that stops fetching
//   fetch_state_t       : instr_fetch FSM states
package cpu_pkg;

  localparam int DEFAULT_INSTR_WIDTH = 20;
  localparam int DEFAULT_PC_BITS     = 5;

  localparam logic [DEFAULT_INSTR_WIDTH-1:0] HALT_INSTR = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_rom.sv
// instr_rom: 2^AW x W instruction memory, one synchronous write port and
// one synchronous read port, no reset (contents survive a core reset).
//   clk    : rising-edge clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled every edge
//   rdata  : registered read data
// A read and a write to the same address on the same edge return the
// newly written word, so a load issued together with a read is visible.
module instr_rom #(
  parameter int W  = 20,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding simple_cpu.instruction.
//   clk, rst        : clock; asynchronous active-low reset (rst=0 resets)
//   prog_we/addr/data : loader write port, honoured only in IDLE or HALT
//   start           : begin (or restart) execution at PC 0 from IDLE/HALT
//   instr_ready     : CPU accepts the presented instruction
//   branch_en/target: redirect the next fetch, sampled on a handshake
//   instruction     : presented word, stable while instr_valid=1
//   instr_valid     : instruction is valid
//   pc              : address of the word being fetched or presented
//   halted          : HALT sentinel reached
//   fetch_state     : current FSM state (debug visibility)
//
// Handshake: a word transfers on an edge where instr_valid and instr_ready
// are both 1. instr_valid, once raised, stays high with instruction and pc
// unchanged until that transfer; instr_ready may toggle freely.
//
// The memory read for a word is launched on the edge that moves the FSM
// into FETCH (its address is the next-cycle pc), so the data sits on the
// read port throughout FETCH and is captured into instruction on entry to
// VALID. That gives one dead cycle between words.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int PC_BITS     = DEFAULT_PC_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  input  logic                   instr_ready,
  input  logic                   branch_en,
  input  logic [PC_BITS-1:0]     branch_target,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   halted,
  output fetch_state_t           fetch_state
);

  fetch_state_t           state, state_d;
  logic [PC_BITS-1:0]     pc_d;
  logic [INSTR_WIDTH-1:0] rdata;
  logic                   rom_we;
  logic                   is_halt;

  // The sentinel is caught after capture, so it is suppressed rather than
  // presented and the FSM parks in HALT on the following edge.
  assign is_halt     = (instruction == {INSTR_WIDTH{1'b1}});
  assign instr_valid = (state == VALID) && !is_halt;
  assign halted      = (state == HALT);
  assign fetch_state = state;
  assign rom_we      = prog_we && ((state == IDLE) || (state == HALT));

  always_comb begin
    state_d = state;
    pc_d    = pc;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = VALID;
      end
      VALID: begin
        if (is_halt) begin
          state_d = HALT;
        end else if (instr_ready) begin
          pc_d    = branch_en ? branch_target : pc + PC_BITS'(1);
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (state == FETCH) begin
        instruction <= rdata;
      end
    end
  end

  instr_rom #(
    .W (INSTR_WIDTH),
    .AW(PC_BITS)
  ) u_rom (
    .clk  (clk),
    .we   (rom_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc_d),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch. The driver
// keeps a reference memory image and program counter; on each start or
// accepted word it pushes the next expected presentation {halt, pc, word}.
// A monitor, sampling 1 time unit before each rising edge, pops and compares
// whenever a new word (or HALT) appears, and checks hold stability and the
// one-cycle gap between words.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int W  = 20;
  localparam int AW = 5;
  localparam int D  = 32;

  logic          clk;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [W-1:0]  prog_data;
  logic          start;
  logic          instr_ready;
  logic          branch_en;
  logic [AW-1:0] branch_target;
  logic [W-1:0]  instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          halted;
  fetch_state_t  fetch_state;

  instr_fetch #(
    .INSTR_WIDTH(W),
    .PC_BITS    (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .start        (start),
    .instr_ready  (instr_ready),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .halted       (halted),
    .fetch_state  (fetch_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model
  logic [W-1:0]      mem_m [D];
  logic [AW-1:0]     model_pc;
  logic [W+AW:0]     exp_q [$];   // {halt, pc, word}

  function automatic logic [W+AW:0] expect_at(input logic [AW-1:0] p);
    logic h;
    h = (mem_m[p] == HALT_INSTR);
    return {h, p, h ? {W{1'b0}} : mem_m[p]};
  endfunction

  function automatic logic [W-1:0] rand_word();
    return W'($urandom_range(0, 20'hFFFFD));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  logic          prev_valid  = 1'b0;
  logic          prev_halted = 1'b0;
  int            low_cnt     = 0;
  logic [W-1:0]  last_instr;
  logic [AW-1:0] last_pc;

  always begin
    logic [W+AW:0] e;
    @(negedge clk);
    #4;
    if (!rst) begin
      prev_valid  = 1'b0;
      prev_halted = 1'b0;
      low_cnt     = 0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_not_halt", 32'(e[W+AW]), 32'd0);
          chk("instr", 32'(instruction), 32'(e[W-1:0]));
          chk("pc", 32'(pc), 32'(e[W+AW-1:W]));
          chk("gap", low_cnt, 1);
        end
      end else if (instr_valid && prev_valid) begin
        chk("hold_instr", 32'(instruction), 32'(last_instr));
        chk("hold_pc", 32'(pc), 32'(last_pc));
      end
      if (halted && !prev_halted) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_halt", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("halt_expected", 32'(e[W+AW]), 32'd1);
          chk("halt_pc", 32'(pc), 32'(e[W+AW-1:W]));
          chk("halt_delay", low_cnt, 2);
        end
      end
      if (halted) chk("valid_in_halt", 32'(instr_valid), 32'd0);
      if (start || (instr_valid && instr_ready)) low_cnt = 0;
      else if (!instr_valid) low_cnt++;
      prev_valid  = instr_valid;
      prev_halted = halted;
      last_instr  = instruction;
      last_pc     = pc;
    end
  end

  // driver tasks
  task automatic write_word(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    mem_m[a] = d;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  task automatic do_start(input bit with_w0, input logic [W-1:0] d0);
    @(negedge clk);
    start = 1'b1;
    if (with_w0) begin
      prog_we = 1'b1; prog_addr = '0; prog_data = d0;
      mem_m[0] = d0;
    end
    model_pc = '0;
    exp_q.push_back(expect_at('0));
    @(posedge clk);
    #1 start = 1'b0; prog_we = 1'b0;
  endtask

  // Accept words until n_hs handshakes were issued (then park on the next
  // presented word with ready low) or until halted. force_tgt >= 0 makes
  // the last handshake a branch to that address.
  task automatic run(input int n_hs, input bit rnd, input int force_tgt);
    int hs;
    int cyc;
    bit done;
    bit br;
    logic [AW-1:0] tgt;
    hs = 0; cyc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      instr_ready = 1'b0; branch_en = 1'b0;
      if (halted) done = 1;
      else if (cyc > 3000) begin
        chk("run_timeout", cyc, 0);
        done = 1;
      end else if (instr_valid && hs >= n_hs) done = 1;
      else if (instr_valid) begin
        instr_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (instr_ready) begin
          br  = rnd && ($urandom_range(0, 3) == 0);
          tgt = AW'($urandom_range(0, D-1));
          if (force_tgt >= 0 && hs == n_hs - 1) begin
            br = 1; tgt = AW'(force_tgt);
          end
          branch_en = br; branch_target = tgt;
          model_pc  = br ? tgt : model_pc + AW'(1);
          exp_q.push_back(expect_at(model_pc));
          hs++;
        end
      end
    end
    instr_ready = 1'b0; branch_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_instr"}, 32'(instruction), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_state"}, 32'(fetch_state), 32'(IDLE));
  endtask

  initial begin
    logic [W-1:0] w;
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; instr_ready = 1'b0; branch_en = 1'b0; branch_target = '0;
    model_pc = '0;
    #2 chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // directed program ending in HALT, ready held high
    write_word(0, 20'h47000);
    write_word(1, 20'h53000);
    write_word(2, 20'h72001);
    write_word(3, 20'hFFFFF);
    do_start(0, '0);
    run(1000, 0, -1);
    chk("halted_a", 32'(halted), 32'd1);

    // fill all 32 words (address 0 written together with start); wrap
    for (int a = 1; a < D; a++) write_word(AW'(a), rand_word());
    do_start(1, rand_word());
    run(34, 0, -1);

    // loader write during VALID must be ignored; ready low holds the word
    w = mem_m[0] ^ 20'h00F0F;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = '0; prog_data = w;
    repeat (5) @(negedge clk);
    prog_we = 1'b0;
    run(1, 0, 0);   // branch to 0: old word expected
    chk("parked_valid", 32'(instr_valid), 32'd1);

    // asynchronous reset while a word is presented
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async");
    chk("queue_empty_reset", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;

    // retained program plus a HALT at 20; random ready and branches
    write_word(20, HALT_INSTR);
    do_start(0, '0);
    run(40, 1, 20);
    chk("halted_c", 32'(halted), 32'd1);

    // loader write in HALT then restart: PC 0 shows the new word
    write_word(0, rand_word());
    do_start(0, '0);
    run(1000, 0, -1);
    chk("halted_d", 32'(halted), 32'd1);

    repeat (3) @(negedge clk);
    chk("queue_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
